// File: rtl/spi_mem_pkg.sv
// Shared constants and FSM state type for the SPI memory master.
package spi_mem_pkg;

    localparam logic [7:0] CMD_WR     = 8'h02;
    localparam logic [7:0] CMD_RD     = 8'h0B;
    localparam int         CMD_BITS   = 8;
    localparam int         ADDR_BITS  = 32;
    localparam int         DATA_BITS  = 32;
    localparam int         FRAME_BITS = CMD_BITS + ADDR_BITS + DATA_BITS;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RDATA,
        WDATA,
        GAP
    } state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI mode-0 clock generator: SCLK idles low while disabled, each level lasts
// CLK_DIV clk_i cycles. rise_o/fall_o are high in the cycle whose closing
// clk_i edge makes SCLK rise/fall, so consumers act on that same edge.
module spi_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    logic [7:0] div_cnt;
    logic       tick;

    assign tick   = en_i && (div_cnt == 8'(CLK_DIV - 1));
    assign rise_o = tick && !sclk_o;
    assign fall_o = tick && sclk_o;

    // Half-period counter; disabling the generator parks SCLK low and restarts the count.
    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            div_cnt <= '0;
            sclk_o  <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            sclk_o  <= ~sclk_o;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_mem_master.sv
// SPI memory master: one 32-bit read (0x0B + dummy cycles) or write (0x02)
// per request. Handshake: a request transfers on a clk_i edge where
// req_valid_i and req_ready_o are both 1; req_ready_o is high only in IDLE and
// never looks at req_valid_i. rsp_valid_o pulses once per completed frame.
module spi_mem_master
    import spi_mem_pkg::*;
#(
    parameter int CLK_DIV      = 2,
    parameter int DUMMY_CYCLES = 32,
    parameter int CS_GAP       = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        spi_sclk_o,
    output logic        spi_cs_o,
    output logic        spi_sdo_o,
    input  logic        spi_sdi_i,
    output state_t      dbg_state_o
);

    localparam logic [7:0] CMD_LAST   = 8'(CMD_BITS - 1);
    localparam logic [7:0] ADDR_LAST  = 8'(ADDR_BITS - 1);
    localparam logic [7:0] DATA_LAST  = 8'(DATA_BITS - 1);
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);
    localparam logic [7:0] GAP_LAST   = 8'(CS_GAP - 1);

    state_t                state, state_n;
    logic [7:0]            bit_cnt, bit_cnt_n;
    logic                  cs_q;
    logic                  we_q;
    logic [FRAME_BITS-1:0] tx_shreg;
    logic [DATA_BITS-1:0]  rx_shreg;
    logic                  sclk_en, sclk_rise, sclk_fall;
    logic                  accept, frame_end;

    assign req_ready_o = (state == IDLE);
    assign accept      = req_valid_i && req_ready_o;
    assign frame_end   = (state != GAP) && (state_n == GAP);
    assign sclk_en     = (state != IDLE) && (state != GAP);
    assign spi_cs_o    = cs_q;
    // Shift register is zero outside the cmd/addr/wdata bits, so the MSB is 0 in DUMMY/RDATA/GAP.
    assign spi_sdo_o   = tx_shreg[FRAME_BITS-1];
    assign dbg_state_o = state;

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (sclk_en),
        .sclk_o (spi_sclk_o),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    // State, phase counter and chip select; CS follows the next state so it moves on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            bit_cnt <= '0;
            cs_q    <= 1'b1;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            cs_q    <= (state_n == IDLE) || (state_n == GAP);
        end
    end

    // Next-state logic: bit phases advance on SCLK falling edges, GAP counts clk_i cycles.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n   = CMD;
                    bit_cnt_n = '0;
                end
            end
            CMD: begin
                if (sclk_fall) begin
                    if (bit_cnt == CMD_LAST) begin
                        state_n   = ADDR;
                        bit_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + 8'd1;
                    end
                end
            end
            ADDR: begin
                if (sclk_fall) begin
                    if (bit_cnt == ADDR_LAST) begin
                        bit_cnt_n = '0;
                        if (we_q)                    state_n = WDATA;
                        else if (DUMMY_CYCLES == 0)  state_n = RDATA;
                        else                         state_n = DUMMY;
                    end else begin
                        bit_cnt_n = bit_cnt + 8'd1;
                    end
                end
            end
            DUMMY: begin
                if (sclk_fall) begin
                    if (bit_cnt == DUMMY_LAST) begin
                        state_n   = RDATA;
                        bit_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + 8'd1;
                    end
                end
            end
            WDATA, RDATA: begin
                if (sclk_fall) begin
                    if (bit_cnt == DATA_LAST) begin
                        state_n   = GAP;
                        bit_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + 8'd1;
                    end
                end
            end
            GAP: begin
                if (bit_cnt == GAP_LAST) begin
                    state_n   = IDLE;
                    bit_cnt_n = '0;
                end else begin
                    bit_cnt_n = bit_cnt + 8'd1;
                end
            end
            default: begin
                state_n   = IDLE;
                bit_cnt_n = '0;
            end
        endcase
    end

    // Datapath: latch the request, shift MOSI on falls, shift MISO on rises, publish the response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q        <= 1'b0;
            tx_shreg    <= '0;
            rx_shreg    <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            if (accept) begin
                we_q     <= req_we_i;
                tx_shreg <= {(req_we_i ? CMD_WR : CMD_RD), req_addr_i,
                             (req_we_i ? req_wdata_i : {DATA_BITS{1'b0}})};
            end else if (sclk_fall) begin
                tx_shreg <= {tx_shreg[FRAME_BITS-2:0], 1'b0};
            end
            if (sclk_rise && (state == RDATA)) begin
                rx_shreg <= {rx_shreg[DATA_BITS-2:0], spi_sdi_i};
            end
            if (frame_end) begin
                rsp_valid_o <= 1'b1;
                if (!we_q) begin
                    rsp_rdata_o <= rx_shreg;
                end
            end
        end
    end

endmodule

// File: doc/spi_mem_master.md
SPI_MEM_MASTER -- requirements
Module: spi_mem_master

Interface
REQ-001 Parameter CLK_DIV, default 2: SCLK half-period in clk_i cycles; legal range 1..255.
REQ-002 Parameter DUMMY_CYCLES, default 32: SCLK cycles between address and read data on reads; legal range 0..255.
REQ-003 Parameter CS_GAP, default 4: minimum clk_i cycles spi_cs stays high between frames; legal range 1..255.
REQ-004 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 req_valid_i  input  1  transaction request.
REQ-007 req_ready_o  output  1  block can accept a request.
REQ-008 req_we_i  input  1  1 = memory write (cmd 0x02), 0 = memory read (cmd 0x0B).
REQ-009 req_addr_i  input  32  target address.
REQ-010 req_wdata_i  input  32  write data.
REQ-011 rsp_valid_o  output  1  one-cycle pulse at transaction completion, for both reads and writes.
REQ-012 rsp_rdata_o  output  32  read data; valid while rsp_valid_o=1 and after a read, until the next read completes.
REQ-013 spi_sclk_o  output  1  SPI clock, mode 0.
REQ-014 spi_cs_o  output  1  active-low chip select.
REQ-015 spi_sdo_o  output  1  master-out serial data, connected to device sdi0.
REQ-016 spi_sdi_i  input  1  master-in serial data, connected from device sdo0.

Function
REQ-017 Handshake: a request SHALL be accepted in a cycle where req_valid_i=1 and req_ready_o=1; req_we_i, req_addr_i and req_wdata_i SHALL be latched in that cycle.
REQ-018 req_ready_o SHALL be 1 only in IDLE and SHALL NOT depend combinationally on req_valid_i.
REQ-019 FSM states: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, GAP.
REQ-020 FSM transitions: IDLE->CMD on accept; CMD->ADDR after 8 bits; ADDR->WDATA (write) or ADDR->DUMMY (read) after 32 bits.
REQ-021 DUMMY->RDATA after DUMMY_CYCLES SCLK cycles; when DUMMY_CYCLES=0, ADDR->RDATA directly.
REQ-022 WDATA/RDATA->GAP after 32 bits; GAP->IDLE after CS_GAP cycles.
REQ-023 spi_cs_o SHALL go low on the clk_i edge following accept and SHALL go high on the clk_i edge that completes the last falling SCLK edge of the frame.
REQ-024 SCLK SHALL idle low; its first rising edge SHALL occur CLK_DIV cycles after spi_cs_o falls; each level SHALL last exactly CLK_DIV cycles.
REQ-025 spi_sdo_o SHALL present the MSB of cmd when spi_cs_o falls and SHALL change only on SCLK falling edges; the device samples on rising edges.
REQ-026 Bit order: cmd[7:0], then addr[31:0], then wdata[31:0], all MSB first.
REQ-027 spi_sdo_o SHALL be 0 during DUMMY, RDATA and GAP.
REQ-028 During RDATA, spi_sdi_i SHALL be sampled on each SCLK rising edge and shifted in MSB first.
REQ-029 Frame length: write = 72 SCLK cycles; read = 72+DUMMY_CYCLES SCLK cycles.
REQ-030 rsp_valid_o SHALL pulse for one cycle on entry to GAP; rsp_rdata_o SHALL update in the same cycle for reads.
REQ-031 req_valid_i asserted outside IDLE SHALL be ignored without side effects.
REQ-032 With req_valid_i held high, back-to-back frames SHALL be separated by exactly CS_GAP+1 cycles of spi_cs_o high.

Reset
REQ-033 Under rst_i: state=IDLE, spi_cs_o=1, spi_sclk_o=0, spi_sdo_o=0, rsp_valid_o=0, rsp_rdata_o=0, req_ready_o=1 from the first cycle after reset.
REQ-034 Reset mid-frame SHALL abort the frame: spi_cs_o high and spi_sclk_o low on the next edge, with no rsp_valid_o pulse.

Structure
REQ-035 Package spi_mem_pkg SHALL hold CMD_WR=8'h02, CMD_RD=8'h0B, ADDR_BITS=32, DATA_BITS=32 and the state enum.
REQ-036 Sub-module spi_sclk_gen SHALL hold the CLK_DIV counter and produce spi_sclk_o plus one-cycle rise/fall strobes; the FSM and shift registers SHALL live in spi_mem_master.

Verification
REQ-037 Write, addr=100, wdata=100, CLK_DIV=2 -> captured MOSI stream 0x02, 0x00000064, 0x00000064; 72 SCLK cycles; one rsp_valid_o pulse.
REQ-038 Read, addr=100, slave model returns 0x00000064 after 32 dummy cycles -> rsp_rdata_o=100; frame = 104 SCLK cycles.
REQ-039 CLK_DIV=1, DUMMY_CYCLES=0, read returning 0xA5A5_5A5A -> correct data; every SCLK level 1 cycle; no DUMMY state visited.
REQ-040 req_valid_i held high for two writes -> second accepted only after GAP; spi_cs_o high for exactly CS_GAP+1 cycles between frames.
REQ-041 rst_i asserted at SCLK cycle 20 of a write -> spi_cs_o=1 and spi_sclk_o=0 next cycle; no rsp_valid_o; a following read completes correctly.
REQ-042 req_valid_i pulsed mid-frame -> ignored; frame content unchanged.
